// File: rtl/instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// instr_fetch_unit
//
// Purpose:
//   Single-outstanding instruction fetch engine. It issues one request per
//   architectural PC, waits for the memory response, holds the returned word
//   until the execute stage supplies the next PC, then fetches again. A
//   misaligned next PC or a memory response that never arrives parks the unit
//   in a sticky fault state. Only reset leaves that state.
//
// Parameters:
//   RESET_PC  PC loaded on reset.
//   TIMEOUT   number of response-less WAIT cycles that trigger a fault.
//
// Ports:
//   i_clk            single clock; all state changes on the rising edge
//   i_reset          synchronous, active-high reset
//   i_next_pc        next PC from the next-PC logic (used as-is, no addition)
//   i_next_pc_valid  execute stage is done with the current instruction
//   i_imem_ready     memory accepts the request this cycle
//   i_imem_rvalid    i_imem_rdata is valid this cycle
//   i_imem_rdata     instruction word from memory
//   o_imem_req       fetch request valid (FETCH state only)
//   o_imem_addr      fetch address, always equal to o_current_pc
//   o_current_pc     PC of the instruction being fetched or held
//   o_instruction    held instruction word
//   o_instr_valid    o_instruction is valid for o_current_pc
//   o_fault          sticky fault flag (misaligned next PC or fetch timeout)
//   o_fetch_count    number of completed fetches (wraps silently)
// -----------------------------------------------------------------------------
module instr_fetch_unit #(
  parameter logic [63:0] RESET_PC = 64'h0,
  parameter int unsigned TIMEOUT  = 16
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [63:0] i_next_pc,
  input  logic        i_next_pc_valid,
  input  logic        i_imem_ready,
  input  logic        i_imem_rvalid,
  input  logic [31:0] i_imem_rdata,
  output logic        o_imem_req,
  output logic [63:0] o_imem_addr,
  output logic [63:0] o_current_pc,
  output logic [31:0] o_instruction,
  output logic        o_instr_valid,
  output logic        o_fault,
  output logic [31:0] o_fetch_count
);

  typedef enum logic [1:0] {
    StFetch,
    StWait,
    StHold,
    StFault
  } state_e;

  state_e      r_state;
  logic [63:0] r_current_pc;
  logic [31:0] r_instruction;
  logic        r_instr_valid;
  logic        r_fault;
  logic [31:0] r_fetch_count;
  logic [31:0] r_timeout_cnt;
  logic        r_imem_req;

  logic [31:0] w_timeout_next;
  logic        w_timeout_hit;
  logic        w_misaligned;

  // The counter value after this WAIT cycle; the fault fires on the edge where
  // it would reach TIMEOUT, unless a response arrives on that same edge.
  assign w_timeout_next = r_timeout_cnt + 32'd1;
  assign w_timeout_hit  = (w_timeout_next >= TIMEOUT);
  assign w_misaligned   = (i_next_pc[1:0] != 2'b00);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state       <= StFetch;
      r_current_pc  <= RESET_PC;
      r_instruction <= 32'h0;
      r_instr_valid <= 1'b0;
      r_fault       <= 1'b0;
      r_fetch_count <= 32'h0;
      r_timeout_cnt <= 32'h0;
      // Request is registered, so it must already be high when leaving reset.
      r_imem_req    <= 1'b1;
    end else begin
      unique case (r_state)
        StFetch: begin
          // Responses and next-PC strobes are ignored here.
          if (i_imem_ready) begin
            r_state       <= StWait;
            r_imem_req    <= 1'b0;
            r_timeout_cnt <= 32'h0;
          end
        end

        StWait: begin
          // A response wins over a timeout reached on the same edge.
          if (i_imem_rvalid) begin
            r_state       <= StHold;
            r_instruction <= i_imem_rdata;
            r_instr_valid <= 1'b1;
            r_fetch_count <= r_fetch_count + 32'd1;
          end else if (w_timeout_hit) begin
            r_state       <= StFault;
            r_fault       <= 1'b1;
            r_timeout_cnt <= w_timeout_next;
          end else begin
            r_timeout_cnt <= w_timeout_next;
          end
        end

        StHold: begin
          if (i_next_pc_valid) begin
            r_instr_valid <= 1'b0;
            if (w_misaligned) begin
              // PC stays on the instruction that produced the bad target.
              r_state <= StFault;
              r_fault <= 1'b1;
            end else begin
              r_state      <= StFetch;
              r_current_pc <= i_next_pc;
              r_imem_req   <= 1'b1;
            end
          end
        end

        StFault: begin
          // Terminal until reset: no request, no valid, PC frozen.
          r_imem_req    <= 1'b0;
          r_instr_valid <= 1'b0;
        end
      endcase
    end
  end

  assign o_imem_req    = r_imem_req;
  assign o_imem_addr   = r_current_pc;
  assign o_current_pc  = r_current_pc;
  assign o_instruction = r_instruction;
  assign o_instr_valid = r_instr_valid;
  assign o_fault       = r_fault;
  assign o_fetch_count = r_fetch_count;

endmodule

// File: tb/tb_instr_fetch_unit.sv
module tb_instr_fetch_unit;

  localparam logic [63:0] RESET_PC = 64'h0;
  localparam int unsigned TIMEOUT  = 16;

  logic        clk = 1'b0;
  logic        i_reset;
  logic [63:0] i_next_pc;
  logic        i_next_pc_valid;
  logic        i_imem_ready;
  logic        i_imem_rvalid;
  logic [31:0] i_imem_rdata;
  logic        o_imem_req;
  logic [63:0] o_imem_addr;
  logic [63:0] o_current_pc;
  logic [31:0] o_instruction;
  logic        o_instr_valid;
  logic        o_fault;
  logic [31:0] o_fetch_count;

  always #5 clk = ~clk;

  instr_fetch_unit #(
    .RESET_PC(RESET_PC),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .i_clk          (clk),
    .i_reset        (i_reset),
    .i_next_pc      (i_next_pc),
    .i_next_pc_valid(i_next_pc_valid),
    .i_imem_ready   (i_imem_ready),
    .i_imem_rvalid  (i_imem_rvalid),
    .i_imem_rdata   (i_imem_rdata),
    .o_imem_req     (o_imem_req),
    .o_imem_addr    (o_imem_addr),
    .o_current_pc   (o_current_pc),
    .o_instruction  (o_instruction),
    .o_instr_valid  (o_instr_valid),
    .o_fault        (o_fault),
    .o_fetch_count  (o_fetch_count)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Transaction-level reference state.
  logic [63:0] exp_pc;
  logic [31:0] exp_instr;
  logic [31:0] exp_count;
  logic        exp_fault;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string tag, input logic exp_req, input logic exp_valid);
    chk($sformatf("%s.req", tag), 64'(o_imem_req), 64'(exp_req));
    chk($sformatf("%s.addr", tag), o_imem_addr, exp_pc);
    chk($sformatf("%s.pc", tag), o_current_pc, exp_pc);
    chk($sformatf("%s.instr", tag), 64'(o_instruction), 64'(exp_instr));
    chk($sformatf("%s.valid", tag), 64'(o_instr_valid), 64'(exp_valid));
    chk($sformatf("%s.fault", tag), 64'(o_fault), 64'(exp_fault));
    chk($sformatf("%s.count", tag), 64'(o_fetch_count), 64'(exp_count));
  endtask

  task automatic rand_noise();
    i_next_pc       = {$urandom(), $urandom()};
    i_next_pc_valid = 1'($urandom_range(0, 1));
    i_imem_rvalid   = 1'($urandom_range(0, 1));
    i_imem_rdata    = $urandom();
  endtask

  task automatic quiet();
    i_next_pc_valid = 1'b0;
    i_imem_ready    = 1'b0;
    i_imem_rvalid   = 1'b0;
  endtask

  task automatic do_reset();
    i_reset = 1'b1;
    rand_noise();
    i_imem_ready = 1'($urandom_range(0, 1));
    step();
    i_reset = 1'b0;
    quiet();
    exp_pc    = RESET_PC;
    exp_instr = 32'h0;
    exp_count = 32'h0;
    exp_fault = 1'b0;
    check_all("reset", 1'b1, 1'b0);
  endtask

  // One request: `stall` cycles of not-ready, then accept; the response comes
  // on WAIT cycle `w` (1-based). If w exceeds TIMEOUT the unit must fault.
  task automatic do_fetch(input int stall, input int w, input logic [31:0] data);
    check_all("fetch_entry", 1'b1, 1'b0);
    for (int i = 0; i < stall; i++) begin
      rand_noise();
      i_imem_ready = 1'b0;
      step();
      check_all("fetch_stall", 1'b1, 1'b0);
    end
    rand_noise();
    i_imem_ready = 1'b1;
    step();
    quiet();
    check_all("wait_entry", 1'b0, 1'b0);
    for (int c = 1; c <= w && c <= int'(TIMEOUT); c++) begin
      rand_noise();
      i_imem_ready  = 1'($urandom_range(0, 1));
      i_imem_rvalid = (c == w);
      if (c == w) i_imem_rdata = data;
      step();
      if (c == w) begin
        exp_instr = data;
        exp_count = exp_count + 32'd1;
        check_all("wait_done", 1'b0, 1'b1);
      end else if (c == int'(TIMEOUT)) begin
        exp_fault = 1'b1;
        check_all("timeout", 1'b0, 1'b0);
      end
    end
    quiet();
  endtask

  task automatic do_hold(input int idle, input logic [63:0] npc);
    for (int i = 0; i < idle; i++) begin
      rand_noise();
      i_next_pc_valid = 1'b0;
      i_imem_ready    = 1'($urandom_range(0, 1));
      step();
      check_all("hold_idle", 1'b0, 1'b1);
    end
    rand_noise();
    i_next_pc_valid = 1'b1;
    i_next_pc       = npc;
    step();
    quiet();
    if (npc[1:0] != 2'b00) begin
      exp_fault = 1'b1;
      check_all("misalign", 1'b0, 1'b0);
    end else begin
      exp_pc = npc;
      check_all("redirect", 1'b1, 1'b0);
    end
  endtask

  task automatic fault_idle(input int n);
    for (int i = 0; i < n; i++) begin
      rand_noise();
      i_imem_ready = 1'($urandom_range(0, 1));
      step();
      check_all("fault_hold", 1'b0, 1'b0);
    end
    quiet();
  endtask

  initial begin
    logic [63:0] npc;
    i_reset      = 1'b1;
    i_next_pc    = 64'h0;
    i_imem_rdata = 32'h0;
    quiet();
    step();
    do_reset();

    // Basic fetch at reset PC, then an aligned redirect.
    do_fetch(0, 1, 32'h8B020020);
    do_hold(0, 64'h40);

    // Memory not ready for 5 cycles.
    do_fetch(5, 2, 32'h12345678);

    // Misaligned target faults and stays faulted.
    do_hold(1, 64'h42);
    fault_idle(4);
    do_reset();

    // No response within TIMEOUT cycles.
    do_fetch(0, int'(TIMEOUT) + 1, 32'hCAFEF00D);
    fault_idle(2);
    do_reset();

    // Response on the exact timeout cycle wins.
    do_fetch(0, int'(TIMEOUT), 32'hA5A5A5A5);
    do_hold(0, 64'h100);

    // Reset mid-WAIT, then a late response while back in FETCH.
    i_imem_ready = 1'b1;
    step();
    i_imem_ready = 1'b0;
    i_reset      = 1'b1;
    step();
    i_reset       = 1'b0;
    i_imem_rvalid = 1'b1;
    i_imem_rdata  = 32'hDEADBEEF;
    step();
    quiet();
    exp_pc    = RESET_PC;
    exp_instr = 32'h0;
    exp_count = 32'h0;
    exp_fault = 1'b0;
    check_all("rst_in_wait", 1'b1, 1'b0);

    // Randomized traffic.
    for (int t = 0; t < 40; t++) begin
      do_fetch(int'($urandom_range(0, 4)), int'($urandom_range(1, TIMEOUT + 2)), $urandom());
      if (exp_fault) begin
        fault_idle(int'($urandom_range(1, 3)));
        do_reset();
      end else begin
        npc = {$urandom(), $urandom()};
        if ($urandom_range(0, 7) != 0) npc[1:0] = 2'b00;
        do_hold(int'($urandom_range(0, 3)), npc);
        if (exp_fault) begin
          fault_idle(int'($urandom_range(1, 3)));
          do_reset();
        end
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 Parameter RESET_PC, 64'h0, PC value loaded on reset.
REQ-002 Parameter TIMEOUT, 16, max cycles waiting for IMemRvalid before fault.
REQ-003 CLK  input  1  single clock; all state changes on rising edge.
REQ-004 Reset  input  1  synchronous, active-high reset.
REQ-005 NextPC  input  64  next PC from next-PC logic, sampled only on NextPCValid.
REQ-006 NextPCValid  input  1  execute stage done with the current instruction; NextPC is valid.
REQ-007 IMemReady  input  1  instruction memory accepts a request this cycle.
REQ-008 IMemRvalid  input  1  IMemRdata is valid this cycle.
REQ-009 IMemRdata  input  32  instruction word returned by memory.
REQ-010 IMemReq  output  1  fetch request valid.
REQ-011 IMemAddr  output  64  fetch address; always equals CurrentPC.
REQ-012 CurrentPC  output  64  architectural PC of the instruction being fetched or held.
REQ-013 Instruction  output  32  held instruction word.
REQ-014 InstrValid  output  1  Instruction is valid for CurrentPC.
REQ-015 Fault  output  1  sticky: misaligned NextPC or fetch timeout.
REQ-016 FetchCount  output  32  number of completed fetches.

Function
REQ-017 FSM states SHALL be FETCH, WAIT, HOLD, FAULT.
- FETCH: IMemReq=1; if IMemReady, go to WAIT; else stay in FETCH.
- WAIT: IMemReq=0; on IMemRvalid, register IMemRdata into Instruction, increment FetchCount, go to HOLD.
- HOLD: InstrValid=1; on NextPCValid, load CurrentPC<=NextPC, clear InstrValid, go to FETCH.
- FAULT: terminal until Reset; IMemReq=0; InstrValid=0; CurrentPC frozen.
REQ-018 IMemReq SHALL be asserted only in FETCH and SHALL remain high until IMemReady; IMemAddr SHALL stay stable while IMemReq=1.
REQ-019 Request-to-instruction latency SHALL be 1 cycle after the IMemRvalid cycle: InstrValid rises on the edge that samples IMemRvalid.
REQ-020 IMemRvalid in FETCH or HOLD SHALL be ignored; it SHALL NOT update Instruction or FetchCount.
REQ-021 NextPCValid outside HOLD SHALL be ignored; CurrentPC SHALL change only on HOLD&&NextPCValid, or on Reset.
REQ-022 If NextPCValid in HOLD with NextPC[1:0]!=0, the unit SHALL go to FAULT, set Fault=1, and leave CurrentPC unchanged.
REQ-023 A timeout counter SHALL clear on entering WAIT and increment each WAIT cycle without IMemRvalid; reaching TIMEOUT SHALL go to FAULT with Fault=1.
REQ-024 IMemRvalid on the same cycle the counter reaches TIMEOUT SHALL take priority; the unit goes to HOLD with no fault.
REQ-025 FetchCount SHALL wrap from 32'hFFFFFFFF to 0 without flagging.
REQ-026 PC arithmetic SHALL be full 64-bit; this block performs no addition. NextPC is used as-is.
REQ-027 Instruction SHALL hold its value until the next accepted IMemRvalid, and SHALL remain readable in FETCH and WAIT.

Reset
REQ-028 On Reset=1 at a clock edge, the unit SHALL set: state=FETCH, CurrentPC=RESET_PC, Instruction=0, InstrValid=0, Fault=0, FetchCount=0, timeout counter=0.
REQ-029 Reset SHALL override every other input in every state, including FAULT and mid-WAIT; a late IMemRvalid after reset falls in FETCH and is ignored under REQ-020.
REQ-030 In the cycle after Reset deasserts, IMemReq SHALL be 1 and IMemAddr SHALL be RESET_PC.

Verification
REQ-031 Reset, then IMemReady=1 and IMemRvalid one cycle later with data 32'h8B020020 -> IMemAddr=0; Instruction=32'h8B020020, InstrValid=1, FetchCount=1.
REQ-032 In HOLD, NextPCValid=1 with NextPC=64'h40 -> next cycle CurrentPC=64'h40, IMemReq=1, InstrValid=0.
REQ-033 IMemReady held 0 for 5 cycles -> IMemReq stays 1 with IMemAddr stable throughout; no state advance.
REQ-034 In HOLD, NextPC=64'h42 with NextPCValid=1 -> Fault=1, CurrentPC unchanged, IMemReq stays 0 until Reset.
REQ-035 In WAIT with no IMemRvalid for TIMEOUT=16 cycles -> Fault=1. Repeat with IMemRvalid on cycle 16 -> HOLD, Fault=0.
REQ-036 Reset asserted in WAIT, then IMemRvalid in the next cycle -> Instruction=0, FetchCount=0, CurrentPC=RESET_PC.
